// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// opcode classes, ALU/operand select codes and trap causes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_IALU,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_ITYPE  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Map a raw 7-bit opcode onto the instruction class the FSM sequences.
    function automatic op_class_t classify(input logic [6:0] opc);
        op_class_t cls;
        case (opc)
            OPC_R:      cls = CLS_R;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_IALU:   cls = CLS_IALU;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Shared memory port handshake between the control unit and memory.
interface multicycle_control_unit_if;
    logic mem_ready;
    logic mem_read;
    logic mem_write;
    logic i_or_d;

    modport master (
        input  mem_ready,
        output mem_read,
        output mem_write,
        output i_or_d
    );

    modport slave (
        output mem_ready,
        input  mem_read,
        input  mem_write,
        input  i_or_d
    );
endinterface

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Watchdog for memory waits: counts consecutive not-ready cycles and flags
// expiry on the last allowed wait cycle. TIMEOUT of 0 removes the counter.
module mem_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT > 0) begin : g_wdog
            logic [TO_W-1:0] count_reg;

            // Wait counter: restarts on every state change, advances while waiting.
            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    count_reg <= '0;
                end else if (enable) begin
                    count_reg <= count_reg + TO_W'(1);
                end
            end

            assign expire = enable && (count_reg == TO_W'(TIMEOUT - 1));
        end else begin : g_no_wdog
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, clear, enable};
            assign expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB
// over one shared memory port, with a bus watchdog, sticky trap and retire counter.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               opcode,
    multicycle_control_unit_if.master mem,
    output logic                     pc_write,
    output logic                     ir_write,
    output logic                     reg_write,
    output logic                     mem_to_reg,
    output logic                     alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               alu_op,
    output logic                     branch,
    output logic                     trap,
    output logic [1:0]               trap_cause,
    output logic                     instr_retired,
    output logic [CNT_W-1:0]         retired_count
);

    // A zero-width counter is meaningless; keep at least one bit.
    localparam int TMR_W = (TO_W > 0) ? TO_W : 1;

    state_t            state_reg, state_next;
    op_class_t         class_reg;
    logic [1:0]        trap_cause_reg, cause_next;
    logic [CNT_W-1:0]  retired_count_reg;
    logic              mem_read_int, mem_write_int, i_or_d_int;
    logic              wait_expire, wait_enable, wait_clear;

    assign wait_enable = ((state_reg == FETCH) || (state_reg == MEM)) && !mem.mem_ready;
    assign wait_clear  = (state_next != state_reg);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TMR_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (wait_clear),
        .enable (wait_enable),
        .expire (wait_expire)
    );

    // State, latched opcode class, trap cause and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= FETCH;
            class_reg         <= CLS_R;
            trap_cause_reg    <= CAUSE_NONE;
            retired_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE) begin
                class_reg <= classify(opcode);
            end
            if ((state_reg != TRAP) && (state_next == TRAP)) begin
                trap_cause_reg <= cause_next;
            end
            if (instr_retired) begin
                retired_count_reg <= retired_count_reg + CNT_W'(1);
            end
        end
    end

    // Next-state and output decode; everything forced low during reset so that
    // an aborted instruction can never strobe a write in the reset cycle.
    always_comb begin
        state_next    = state_reg;
        cause_next    = CAUSE_NONE;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        i_or_d_int    = 1'b0;
        mem_read_int  = 1'b0;
        mem_write_int = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_ADD;
        branch        = 1'b0;
        trap          = 1'b0;
        instr_retired = 1'b0;

        case (state_reg)
            FETCH: begin
                mem_read_int = 1'b1;
                alu_src_b    = SRCB_FOUR;
                if (mem.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end else if (wait_expire) begin
                    cause_next = CAUSE_TIMEOUT;
                    state_next = TRAP;
                end
            end
            DECODE: begin
                if (classify(opcode) == CLS_ILLEGAL) begin
                    cause_next = CAUSE_ILLEGAL;
                    state_next = TRAP;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                case (class_reg)
                    CLS_R: begin
                        alu_src_b  = SRCB_RS2;
                        alu_op     = ALU_RTYPE;
                        state_next = WB;
                    end
                    CLS_IALU: begin
                        alu_src_b  = SRCB_IMM;
                        alu_op     = ALU_ITYPE;
                        state_next = WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b  = SRCB_IMM;
                        alu_op     = ALU_ADD;
                        state_next = MEM;
                    end
                    CLS_BRANCH: begin
                        alu_src_b     = SRCB_RS2;
                        alu_op        = ALU_BRANCH;
                        branch        = 1'b1;
                        instr_retired = 1'b1;
                        state_next    = FETCH;
                    end
                    default: begin
                        cause_next = CAUSE_ILLEGAL;
                        state_next = TRAP;
                    end
                endcase
            end
            MEM: begin
                i_or_d_int    = 1'b1;
                mem_read_int  = (class_reg == CLS_LOAD);
                mem_write_int = (class_reg == CLS_STORE);
                if (mem.mem_ready) begin
                    if (class_reg == CLS_STORE) begin
                        instr_retired = 1'b1;
                        state_next    = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end else if (wait_expire) begin
                    cause_next = CAUSE_TIMEOUT;
                    state_next = TRAP;
                end
            end
            WB: begin
                reg_write     = 1'b1;
                mem_to_reg    = (class_reg == CLS_LOAD);
                instr_retired = 1'b1;
                state_next    = FETCH;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        if (reset) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            i_or_d_int    = 1'b0;
            mem_read_int  = 1'b0;
            mem_write_int = 1'b0;
            reg_write     = 1'b0;
            mem_to_reg    = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = SRCB_RS2;
            alu_op        = ALU_ADD;
            branch        = 1'b0;
            trap          = 1'b0;
            instr_retired = 1'b0;
        end
    end

    assign mem.mem_read   = mem_read_int;
    assign mem.mem_write  = mem_write_int;
    assign mem.i_or_d     = i_or_d_int;
    assign trap_cause     = reset ? CAUSE_NONE : trap_cause_reg;
    assign retired_count  = reset ? '0 : retired_count_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a cycle-by-cycle vector table
// plus hand-written trap-hold and reset-during-store sequences.
module tb_multicycle_control_unit;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic        pc_write, ir_write, reg_write, mem_to_reg, alu_src_a, branch, trap, instr_retired;
    logic [1:0]  alu_src_b, alu_op, trap_cause;
    logic [31:0] retired_count;

    int checks = 0;
    int errors = 0;

    multicycle_control_unit_if bus();

    multicycle_control_unit #(
        .TIMEOUT (4),
        .CNT_W   (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem           (bus),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .branch        (branch),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .instr_retired (instr_retired),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [6:0]  opc;
        logic        rdy;
        logic [16:0] exp;
        logic [31:0] cnt;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Output bundle order: pc_write ir_write i_or_d mem_read mem_write reg_write
    // mem_to_reg alu_src_a alu_src_b[2] alu_op[2] branch trap trap_cause[2] instr_retired
    function automatic logic [16:0] mk(input logic pcw, input logic irw, input logic iod,
                                       input logic mr, input logic mw, input logic rw,
                                       input logic m2r, input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic br, input logic tr,
                                       input logic [1:0] tc, input logic ret);
        return {pcw, irw, iod, mr, mw, rw, m2r, asa, asb, aop, br, tr, tc, ret};
    endfunction

    task automatic add(input logic r, input logic [6:0] o, input logic rd,
                       input logic [16:0] e, input logic [31:0] c, input string nm);
        vec_t v;
        v.rst = r; v.opc = o; v.rdy = rd; v.exp = e; v.cnt = c; v.name = nm;
        vecs.push_back(v);
    endtask

    // Apply one cycle of inputs, compare at the falling edge, advance past the next rising edge.
    task automatic step(input logic r, input logic [6:0] o, input logic rd,
                        input logic [16:0] e, input logic [31:0] c, input string nm);
        logic [16:0] act;
        reset = r;
        opcode = o;
        bus.mem_ready = rd;
        @(negedge clk);
        act = {pc_write, ir_write, bus.i_or_d, bus.mem_read, bus.mem_write, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, branch, trap, trap_cause, instr_retired};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s outputs: got %b required %b", nm, act, e);
        end
        checks++;
        if (retired_count !== c) begin
            errors++;
            $display("FAIL %s retired_count: got %0d required %0d", nm, retired_count, c);
        end
        $display("step %-12s rst=%0b opc=%b rdy=%0b out=%b cnt=%0d", nm, r, o, rd, act, retired_count);
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011;
    localparam logic [6:0] BR_OP = 7'b1100011;
    localparam logic [6:0] IA_OP = 7'b0010011;
    localparam logic [6:0] BAD   = 7'b1111111;

    initial begin
        logic [16:0] p_zero, p_fgo, p_fwait, p_ex_r, p_ex_i, p_ex_ls, p_ex_br;
        logic [16:0] p_mem_ld, p_mem_st, p_mem_st_ret, p_wb_r, p_wb_ld, p_trap_ill, p_trap_to;

        p_zero       = '0;
        p_fgo        = mk(1,1,0,1,0,0,0,0,2'b01,2'b00,0,0,2'b00,0);
        p_fwait      = mk(0,0,0,1,0,0,0,0,2'b01,2'b00,0,0,2'b00,0);
        p_ex_r       = mk(0,0,0,0,0,0,0,1,2'b00,2'b10,0,0,2'b00,0);
        p_ex_i       = mk(0,0,0,0,0,0,0,1,2'b10,2'b11,0,0,2'b00,0);
        p_ex_ls      = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,2'b00,0);
        p_ex_br      = mk(0,0,0,0,0,0,0,1,2'b00,2'b01,1,0,2'b00,1);
        p_mem_ld     = mk(0,0,1,1,0,0,0,0,2'b00,2'b00,0,0,2'b00,0);
        p_mem_st     = mk(0,0,1,0,1,0,0,0,2'b00,2'b00,0,0,2'b00,0);
        p_mem_st_ret = mk(0,0,1,0,1,0,0,0,2'b00,2'b00,0,0,2'b00,1);
        p_wb_r       = mk(0,0,0,0,0,1,0,0,2'b00,2'b00,0,0,2'b00,1);
        p_wb_ld      = mk(0,0,0,0,0,1,1,0,2'b00,2'b00,0,0,2'b00,1);
        p_trap_ill   = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b01,0);
        p_trap_to    = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,0);

        add(1, R_OP, 0, p_zero,   0, "reset");
        // R-type, memory always ready
        add(0, R_OP, 1, p_fgo,    0, "r_fetch");
        add(0, R_OP, 1, p_zero,   0, "r_decode");
        add(0, R_OP, 1, p_ex_r,   0, "r_exec");
        add(0, R_OP, 1, p_wb_r,   0, "r_wb");
        // Load with three wait cycles in MEM
        add(0, LD_OP, 1, p_fgo,    1, "ld_fetch");
        add(0, LD_OP, 1, p_zero,   1, "ld_decode");
        add(0, LD_OP, 1, p_ex_ls,  1, "ld_exec");
        add(0, LD_OP, 0, p_mem_ld, 1, "ld_mem_w1");
        add(0, LD_OP, 0, p_mem_ld, 1, "ld_mem_w2");
        add(0, LD_OP, 0, p_mem_ld, 1, "ld_mem_w3");
        add(0, LD_OP, 1, p_mem_ld, 1, "ld_mem_rdy");
        add(0, LD_OP, 1, p_wb_ld,  1, "ld_wb");
        // Store retires from MEM
        add(0, ST_OP, 1, p_fgo,        2, "st_fetch");
        add(0, ST_OP, 1, p_zero,       2, "st_decode");
        add(0, ST_OP, 1, p_ex_ls,      2, "st_exec");
        add(0, ST_OP, 1, p_mem_st_ret, 2, "st_mem");
        // Branch retires from EXEC
        add(0, BR_OP, 1, p_fgo,   3, "br_fetch");
        add(0, BR_OP, 1, p_zero,  3, "br_decode");
        add(0, BR_OP, 1, p_ex_br, 3, "br_exec");
        // I-type ALU
        add(0, IA_OP, 1, p_fgo,  4, "ia_fetch");
        add(0, IA_OP, 1, p_zero, 4, "ia_decode");
        add(0, IA_OP, 1, p_ex_i, 4, "ia_exec");
        add(0, IA_OP, 1, p_wb_r, 4, "ia_wb");
        // Fetch watchdog: four wait cycles then trap
        add(0, R_OP, 0, p_fwait,   5, "to_w1");
        add(0, R_OP, 0, p_fwait,   5, "to_w2");
        add(0, R_OP, 0, p_fwait,   5, "to_w3");
        add(0, R_OP, 0, p_fwait,   5, "to_w4");
        add(0, R_OP, 0, p_trap_to, 5, "to_trap");
        add(1, R_OP, 0, p_zero,    0, "to_reset");
        // Ready on the fourth wait cycle wins over the watchdog
        add(0, BAD, 0, p_fwait,    0, "rw_w1");
        add(0, BAD, 0, p_fwait,    0, "rw_w2");
        add(0, BAD, 0, p_fwait,    0, "rw_w3");
        add(0, BAD, 1, p_fgo,      0, "rw_rdy");
        // Illegal opcode traps after DECODE
        add(0, BAD, 1, p_zero,     0, "ill_decode");
        add(0, BAD, 1, p_trap_ill, 0, "ill_trap");

        reset = 1'b1;
        opcode = '0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].opc, vecs[i].rdy, vecs[i].exp, vecs[i].cnt, vecs[i].name);
        end

        // Trap is sticky regardless of memory activity
        for (int k = 0; k < 20; k++) begin
            step(0, R_OP, k[0], p_trap_ill, 0, "ill_hold");
        end
        step(1, R_OP, 1, p_zero,  0, "ill_reset");
        step(0, R_OP, 0, p_fwait, 0, "ill_refetch");

        // Reset in the middle of a store wait aborts it without a write strobe
        step(0, ST_OP, 1, p_fgo,    0, "rs_fetch");
        step(0, ST_OP, 1, p_zero,   0, "rs_decode");
        step(0, ST_OP, 1, p_ex_ls,  0, "rs_exec");
        step(0, ST_OP, 0, p_mem_st, 0, "rs_mem");
        step(1, ST_OP, 1, p_zero,   0, "rs_reset");
        step(0, ST_OP, 0, p_fwait,  0, "rs_fetch2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
